// File: rtl/axil_insn_rom.sv
// axil_insn_rom
//   AXI4-lite read-only responder that serves instruction words from an
//   on-chip memory. The memory is loaded through a separate synchronous
//   write port owned by the debug/host side and is not cleared by reset.
//
//   An AR request is accepted whenever fewer than two responses are
//   outstanding. The memory word is captured into a 2-entry response FIFO
//   on the accepting edge, so R data is valid in the cycle that follows the
//   AR handshake. With RREADY held high this sustains one beat per cycle.
//
// Ports
//   S_AXI_ACLK     in   clock
//   S_AXI_ARESETN  in   asynchronous active-low reset
//   S_AXI_ARVALID  in   read address valid
//   S_AXI_ARREADY  out  read address ready (registered occupancy only)
//   S_AXI_ARADDR   in   byte address
//   S_AXI_ARPROT   in   protection bits (ignored)
//   S_AXI_RVALID   out  read data valid
//   S_AXI_RREADY   in   read data ready
//   S_AXI_RDATA    out  read data
//   S_AXI_RRESP    out  2'b00 OKAY, 2'b11 DECERR
//   i_we           in   load-port write strobe
//   i_waddr        in   load-port word index
//   i_wdata        in   load-port write data
module axil_insn_rom #(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 64,
  parameter int LGMEMSZ          = 12,
  localparam int AXILLSB         = $clog2(C_AXI_DATA_WIDTH / 8),
  localparam int WIDX_W          = LGMEMSZ - AXILLSB,
  localparam int NWORDS          = 1 << WIDX_W
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESETN,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                  S_AXI_ARPROT,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  output logic [C_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  input  logic                        i_we,
  input  logic [WIDX_W-1:0]           i_waddr,
  input  logic [C_AXI_DATA_WIDTH-1:0] i_wdata
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [C_AXI_DATA_WIDTH-1:0] r_mem [NWORDS];

  // Response FIFO storage (data path, never reset) and its control state.
  logic [C_AXI_DATA_WIDTH-1:0] r_buf_data_p0 [2];
  logic [1:0]                  r_buf_resp_p0 [2];
  logic [1:0]                  r_occ;
  logic                        r_wptr;
  logic                        r_rptr;

  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_in_range;
  logic [WIDX_W-1:0] w_ridx;
  logic              w_unused;

  // Every accepted request is pushed into the FIFO on the same edge, so the
  // outstanding-request count is also the FIFO fill level.
  assign S_AXI_ARREADY = S_AXI_ARESETN && (r_occ != 2'd2);
  assign S_AXI_RVALID  = (r_occ != 2'd0);
  assign S_AXI_RDATA   = r_buf_data_p0[r_rptr];
  assign S_AXI_RRESP   = S_AXI_RVALID ? r_buf_resp_p0[r_rptr] : RESP_OKAY;

  assign w_ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_r_hs     = S_AXI_RVALID && S_AXI_RREADY;
  // A shift handles LGMEMSZ == C_AXI_ADDR_WIDTH, where no upper bits exist.
  assign w_in_range = ((S_AXI_ARADDR >> LGMEMSZ) == '0);
  assign w_ridx     = S_AXI_ARADDR[LGMEMSZ-1:AXILLSB];

  // Byte-lane bits and ARPROT carry no meaning for a word-wide ROM.
  assign w_unused = &{1'b0, S_AXI_ARPROT, S_AXI_ARADDR[AXILLSB-1:0]};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_occ  <= 2'd0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
    end else begin
      if (w_ar_hs && !w_r_hs) begin
        r_occ <= r_occ + 2'd1;
      end else if (w_r_hs && !w_ar_hs) begin
        r_occ <= r_occ - 2'd1;
      end
      if (w_ar_hs) begin
        r_wptr <= ~r_wptr;
      end
      if (w_r_hs) begin
        r_rptr <= ~r_rptr;
      end
    end
  end

  // ---- stage p0: memory read into the response FIFO on AR acceptance ----
  // Nonblocking read and load of r_mem on the same edge gives read-first
  // behaviour for a colliding load.
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_ar_hs) begin
      if (w_in_range) begin
        r_buf_data_p0[r_wptr] <= r_mem[w_ridx];
        r_buf_resp_p0[r_wptr] <= RESP_OKAY;
      end else begin
        r_buf_data_p0[r_wptr] <= '0;
        r_buf_resp_p0[r_wptr] <= RESP_DECERR;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: tb/tb_axil_insn_rom.sv
module tb_axil_insn_rom;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int LG = 12;
  localparam int NW = 512;

  logic          clk;
  logic          rst_n;
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          we;
  logic [8:0]    waddr;
  logic [DW-1:0] wdata;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: memory image and ordered list of expected {resp, data}.
  logic [DW-1:0] mmem [NW];
  logic [65:0]   exp_q [$];

  axil_insn_rom #(
    .C_AXI_ADDR_WIDTH(AW),
    .C_AXI_DATA_WIDTH(DW),
    .LGMEMSZ(LG)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .i_we(we),
    .i_waddr(waddr),
    .i_wdata(wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [65:0] model_resp(input logic [AW-1:0] a);
    if (a >= (1 << LG)) return {2'b11, 64'd0};
    return {2'b00, mmem[(a % (1 << LG)) / 8]};
  endfunction

  // Advance one clock, updating the model with what the current inputs and
  // outputs imply at the coming edge. The model read happens before the
  // model load so a colliding load returns the old word.
  task automatic cycle();
    logic ar_hs;
    logic r_hs;
    ar_hs = arvalid && arready;
    r_hs  = rvalid && rready;
    if (r_hs && exp_q.size() > 0) void'(exp_q.pop_front());
    if (ar_hs) exp_q.push_back(model_resp(araddr));
    if (we) mmem[waddr] = wdata;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; arvalid = 1'b0; araddr = '0; arprot = 3'b0;
    rready = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    n_total++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid got=%b want=0", rvalid); else n_pass++;
    n_total++; if (arready !== 1'b0) $display("FAIL reset_arready got=%b want=0", arready); else n_pass++;
    n_total++; if (rresp !== 2'b00) $display("FAIL reset_rresp got=%b want=00", rresp); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++; if (arready !== 1'b1) $display("FAIL release_arready got=%b want=1", arready); else n_pass++;
    @(negedge clk);
    // Fill the whole memory so every later read has defined contents.
    for (int i = 0; i < NW; i++) begin
      we = 1'b1; waddr = 9'(i); wdata = {$urandom(), $urandom()};
      cycle();
    end
    we = 1'b0;
  endtask

  task automatic test_basic();
    we = 1'b1; waddr = 9'd3; wdata = 64'h1122334455667788;
    cycle();
    we = 1'b0;
    arvalid = 1'b1; araddr = 32'h18; rready = 1'b1;
    n_total++; if (arready !== 1'b1) $display("FAIL basic_arready got=%b want=1", arready); else n_pass++;
    cycle();
    arvalid = 1'b0;
    n_total++; if (rvalid !== 1'b1) $display("FAIL basic_latency rvalid got=%b want=1", rvalid); else n_pass++;
    n_total++; if (rdata !== 64'h1122334455667788) $display("FAIL basic_rdata got=%h want=1122334455667788", rdata); else n_pass++;
    n_total++; if (rresp !== 2'b00) $display("FAIL basic_rresp got=%b want=00", rresp); else n_pass++;
    cycle();
    n_total++; if (rvalid !== 1'b0) $display("FAIL basic_single_beat rvalid got=%b want=0", rvalid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    rready = 1'b1; arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      araddr = 32'(i * 8);
      n_total++; if (arready !== 1'b1) $display("FAIL b2b_arready[%0d] got=%b want=1", i, arready); else n_pass++;
      if (i > 0) begin
        n_total++; if (rvalid !== 1'b1 || rdata !== mmem[i-1]) $display("FAIL b2b_beat[%0d] got v=%b d=%h want v=1 d=%h", i-1, rvalid, rdata, mmem[i-1]); else n_pass++;
      end
      cycle();
    end
    arvalid = 1'b0;
    n_total++; if (rvalid !== 1'b1 || rdata !== mmem[3]) $display("FAIL b2b_beat[3] got v=%b d=%h want v=1 d=%h", rvalid, rdata, mmem[3]); else n_pass++;
    cycle();
    n_total++; if (rvalid !== 1'b0) $display("FAIL b2b_drain rvalid got=%b want=0", rvalid); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    rready = 1'b0; arvalid = 1'b1; araddr = 32'h20;
    n_total++; if (arready !== 1'b1) $display("FAIL bp_first_arready got=%b want=1", arready); else n_pass++;
    cycle();
    araddr = 32'h28;
    n_total++; if (arready !== 1'b1) $display("FAIL bp_second_arready got=%b want=1", arready); else n_pass++;
    cycle();
    araddr = 32'h30;
    n_total++; if (arready !== 1'b0) $display("FAIL bp_full_arready got=%b want=0", arready); else n_pass++;
    held = rdata;
    cycle();
    n_total++; if (arready !== 1'b0) $display("FAIL bp_still_full got=%b want=0", arready); else n_pass++;
    n_total++; if (rdata !== held || rdata !== mmem[4]) $display("FAIL bp_stable_rdata got=%h want=%h", rdata, mmem[4]); else n_pass++;
    rready = 1'b1;
    cycle();
    n_total++; if (arready !== 1'b1) $display("FAIL bp_reopen_arready got=%b want=1", arready); else n_pass++;
    n_total++; if (rvalid !== 1'b1 || rdata !== mmem[5]) $display("FAIL bp_beat2 got v=%b d=%h want v=1 d=%h", rvalid, rdata, mmem[5]); else n_pass++;
    cycle();
    arvalid = 1'b0;
    n_total++; if (rvalid !== 1'b1 || rdata !== mmem[6]) $display("FAIL bp_beat3 got v=%b d=%h want v=1 d=%h", rvalid, rdata, mmem[6]); else n_pass++;
    cycle();
    n_total++; if (rvalid !== 1'b0) $display("FAIL bp_drain rvalid got=%b want=0", rvalid); else n_pass++;
  endtask

  task automatic test_decerr();
    rready = 1'b1; arvalid = 1'b1; araddr = 32'h0000_1000;
    cycle();
    araddr = 32'h40;
    n_total++; if (rresp !== 2'b11 || rdata !== 64'd0) $display("FAIL decerr got r=%b d=%h want r=11 d=0", rresp, rdata); else n_pass++;
    cycle();
    arvalid = 1'b0;
    n_total++; if (rresp !== 2'b00 || rdata !== mmem[8]) $display("FAIL after_decerr got r=%b d=%h want r=00 d=%h", rresp, rdata, mmem[8]); else n_pass++;
    cycle();
  endtask

  task automatic test_read_first();
    logic [DW-1:0] va;
    logic [DW-1:0] vb;
    va = 64'hAAAA_5555_0123_4567;
    vb = 64'hBBBB_6666_89AB_CDEF;
    we = 1'b1; waddr = 9'd5; wdata = vb;
    cycle();
    wdata = va; arvalid = 1'b1; araddr = 32'h28; rready = 1'b1;
    cycle();
    we = 1'b0;
    n_total++; if (rdata !== vb) $display("FAIL read_first_old got=%h want=%h", rdata, vb); else n_pass++;
    cycle();
    araddr = 32'h2C;
    n_total++; if (rdata !== va) $display("FAIL read_after_load got=%h want=%h", rdata, va); else n_pass++;
    cycle();
    arvalid = 1'b0;
    n_total++; if (rdata !== va || rresp !== 2'b00) $display("FAIL unaligned got r=%b d=%h want r=00 d=%h", rresp, rdata, va); else n_pass++;
    cycle();
  endtask

  task automatic test_reset_mid();
    rready = 1'b0; arvalid = 1'b1; araddr = 32'h0;
    cycle();
    cycle();
    arvalid = 1'b0;
    n_total++; if (rvalid !== 1'b1 || arready !== 1'b0) $display("FAIL mid_full got v=%b ar=%b want v=1 ar=0", rvalid, arready); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (rvalid !== 1'b0) $display("FAIL async_rvalid_drop got=%b want=0", rvalid); else n_pass++;
    @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    #1;
    n_total++; if (arready !== 1'b1 || rvalid !== 1'b0) $display("FAIL post_reset got ar=%b v=%b want ar=1 v=0", arready, rvalid); else n_pass++;
    @(negedge clk);
    rready = 1'b1;
    cycle();
    n_total++; if (rvalid !== 1'b0) $display("FAIL stale_beat rvalid got=%b want=0", rvalid); else n_pass++;
    arvalid = 1'b1; araddr = 32'h18;
    cycle();
    arvalid = 1'b0;
    n_total++; if (rvalid !== 1'b1 || rdata !== mmem[3]) $display("FAIL fresh_after_reset got v=%b d=%h want v=1 d=%h", rvalid, rdata, mmem[3]); else n_pass++;
    cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      arvalid = ($urandom_range(3) != 0);
      araddr  = ($urandom_range(7) == 0) ? (32'h1000 | 32'($urandom())) : 32'($urandom_range(4095));
      arprot  = 3'($urandom());
      rready  = ($urandom_range(3) != 0);
      we      = ($urandom_range(3) == 0);
      waddr   = 9'($urandom());
      wdata   = {$urandom(), $urandom()};
      n_total++; if (rvalid !== (exp_q.size() != 0)) $display("FAIL rnd_rvalid[%0d] got=%b want=%b", c, rvalid, exp_q.size() != 0); else n_pass++;
      n_total++; if (arready !== (exp_q.size() < 2)) $display("FAIL rnd_arready[%0d] got=%b want=%b", c, arready, exp_q.size() < 2); else n_pass++;
      if (rvalid && rready && exp_q.size() > 0) begin
        n_total++; if ({rresp, rdata} !== exp_q[0]) $display("FAIL rnd_beat[%0d] got=%h want=%h", c, {rresp, rdata}, exp_q[0]); else n_pass++;
      end
      cycle();
    end
    arvalid = 1'b0; we = 1'b0; rready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (rvalid && exp_q.size() > 0) begin
        n_total++; if ({rresp, rdata} !== exp_q[0]) $display("FAIL rnd_drain[%0d] got=%h want=%h", c, {rresp, rdata}, exp_q[0]); else n_pass++;
      end
      cycle();
    end
    n_total++; if (rvalid !== 1'b0 || exp_q.size() != 0) $display("FAIL rnd_final got v=%b pending=%0d want v=0 pending=0", rvalid, exp_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_decerr();
    test_read_first();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
